// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the E stage.
// Holds E (ok=0) while a MULT/MULTU/DIV/DIVU is in flight.
module muldiv_unit #(
    parameter int MULT_LAT = 3,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        advance,
    input  logic        flush,
    output logic        ok,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam logic [5:0] MulLoad = 6'(MULT_LAT - 1);
    localparam logic [5:0] DivLoad = 6'(DIV_ITER - 1);

    stateT       state;
    stateT       stateNext;
    logic        start;
    logic        last;
    logic [5:0]  cnt;
    logic        isSigned;
    logic [31:0] aReg;
    logic [31:0] bReg;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;

    logic        aNeg;
    logic        bNeg;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] remStep;
    logic [31:0] quoStep;
    logic        negQ;
    logic        negR;
    logic [31:0] quoFix;
    logic [31:0] remFix;
    logic        divZero;
    logic [31:0] hiDiv;
    logic [31:0] loDiv;
    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [63:0] product;

    assign start = (state == IDLE) & valid & ~flush;
    assign last  = (cnt == 6'd0);

    // Magnitudes for signed division; 0x80000000 maps to 2^31 unsigned.
    assign aNeg = ~op[0] & a[31];
    assign bNeg = ~op[0] & b[31];
    assign aMag = aNeg ? (~a + 32'd1) : a;
    assign bMag = bNeg ? (~b + 32'd1) : b;

    // One restoring step: partial remainder never exceeds the divisor.
    assign shifted = {rem, quo[31]};
    assign ge      = shifted >= {1'b0, dvsr};
    assign remStep = ge ? (shifted[31:0] - dvsr) : shifted[31:0];
    assign quoStep = {quo[30:0], ge};

    assign negQ    = isSigned & (aReg[31] ^ bReg[31]);
    assign negR    = isSigned & aReg[31];
    assign quoFix  = negQ ? (~quoStep + 32'd1) : quoStep;
    assign remFix  = negR ? (~remStep + 32'd1) : remStep;
    assign divZero = (bReg == 32'd0);
    assign loDiv   = divZero ? 32'hFFFF_FFFF : quoFix;
    assign hiDiv   = divZero ? aReg : remFix;

    // Low 64 bits of extended operands give both signed and unsigned products.
    assign aExt    = isSigned ? {{32{aReg[31]}}, aReg} : {32'd0, aReg};
    assign bExt    = isSigned ? {{32{bReg[31]}}, bReg} : {32'd0, bReg};
    assign product = aExt * bExt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (last) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (flush || advance) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ok = 1'b1;
        if (!flush) begin
            unique case (state)
                IDLE:     ok = ~valid;
                MUL, DIV: ok = 1'b0;
                default:  ok = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= 6'd0;
            isSigned <= 1'b0;
            aReg     <= 32'd0;
            bReg     <= 32'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            dvsr     <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (start) begin
            cnt      <= op[1] ? DivLoad : MulLoad;
            isSigned <= ~op[0];
            aReg     <= a;
            bReg     <= b;
            quo      <= aMag;
            rem      <= 32'd0;
            dvsr     <= bMag;
        end else if (!flush) begin
            if ((state == MUL || state == DIV) && !last) begin
                cnt <= cnt - 6'd1;
            end
            if (state == DIV) begin
                rem <= remStep;
                quo <= quoStep;
            end
            if (state == MUL && last) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
            if (state == DIV && last) begin
                hi <= hiDiv;
                lo <= loDiv;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, corner sequences,
// and random ops against an arithmetic reference.
module tb_muldiv_unit;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        advance;
    logic        flush;
    logic        ok;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    logic [63:0] lastRes;

    muldiv_unit #(
        .MULT_LAT(3),
        .DIV_ITER(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .valid(valid),
        .op(op),
        .a(a),
        .b(b),
        .advance(advance),
        .flush(flush),
        .ok(ok),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vecT;

    vecT vecs [10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint p;
        int sx;
        int sy;
        int q;
        int r;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin
                p = longint'(sx) * longint'(sy);
                return p;
            end
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic int modelLat(input logic [1:0] o);
        return o[1] ? 33 : 4;
    endfunction

    // Starts in an IDLE cycle, scrambles inputs while busy, and
    // leaves the unit back in IDLE one cycle after DONE.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp,
                         input int lat, input string name);
        int c;
        c = 0;
        valid = 1'b1;
        op = o;
        a = x;
        b = y;
        advance = 1'b1;
        flush = 1'b0;
        #1;
        while (!ok && c < 100) begin
            @(posedge clk);
            #1;
            c++;
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            #1;
        end
        check({name, "_lat"}, 64'(c), 64'(lat));
        check({name, "_hi"}, 64'(hi), 64'(exp[63:32]));
        check({name, "_lo"}, 64'(lo), 64'(exp[31:0]));
        lastRes = exp;
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        logic [1:0] ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4};
        vecs[1] = '{2'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 4};
        vecs[2] = '{2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
        vecs[5] = '{2'd3, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 33};
        vecs[6] = '{2'd2, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 33};
        vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4};
        vecs[8] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
        vecs[9] = '{2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_0000_0001, 33};

        checks = 0;
        failures = 0;
        lastRes = 64'd0;
        clk = 1'b0;
        resetn = 1'b0;
        valid = 1'b0;
        op = 2'd0;
        a = 32'd0;
        b = 32'd0;
        advance = 1'b1;
        flush = 1'b0;

        #3;
        check("rst_ok", 64'(ok), 64'd1);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        #9 resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                  vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Flush in IDLE with valid must not start an op.
        valid = 1'b1;
        op = 2'd0;
        a = 32'd5;
        b = 32'd6;
        flush = 1'b1;
        #1;
        check("idleflush_ok", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        #1;
        check("idleflush_nostart", 64'(ok), 64'd1);
        check("idleflush_hold", {hi, lo}, lastRes);

        // Flush a divide at cycle 10, then restart with full latency.
        valid = 1'b1;
        op = 2'd2;
        a = 32'd1000;
        b = 32'd3;
        #1;
        check("dflush_start_ok", 64'(ok), 64'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("dflush_busy_ok", 64'(ok), 64'd0);
        flush = 1'b1;
        #1;
        check("dflush_ok", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        #1;
        check("dflush_idle_ok", 64'(ok), 64'd1);
        check("dflush_hold", {hi, lo}, lastRes);
        runOp(2'd2, 32'd1000, 32'd3, model(2'd2, 32'd1000, 32'd3), 33, "dflush_restart");

        // DONE held by advance=0 with valid still asserted.
        exp = model(2'd0, 32'h0001_0003, 32'hFFFF_0005);
        valid = 1'b1;
        op = 2'd0;
        a = 32'h0001_0003;
        b = 32'hFFFF_0005;
        advance = 1'b0;
        c = 0;
        #1;
        while (!ok && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("stall_lat", 64'(c), 64'd4);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_ok", 64'(ok), 64'd1);
            check("stall_res", {hi, lo}, exp);
        end
        lastRes = exp;
        valid = 1'b0;
        advance = 1'b1;
        @(posedge clk);
        #1;
        check("stall_idle_ok", 64'(ok), 64'd1);
        check("stall_idle_res", {hi, lo}, lastRes);

        // Asynchronous reset in the middle of a divide.
        valid = 1'b1;
        op = 2'd3;
        a = 32'd77;
        b = 32'd5;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        #1;
        check("prerst_ok", 64'(ok), 64'd0);
        resetn = 1'b0;
        #1;
        check("midrst_ok", 64'(ok), 64'd1);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        lastRes = 64'd0;
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ok", 64'(ok), 64'd1);
        runOp(2'd3, 32'd77, 32'd5, model(2'd3, 32'd77, 32'd5), 33, "postrst");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'd1;
                3: rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            runOp(ro, ra, rb, model(ro, ra, rb), modelLat(ro),
                  $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
